// File: rtl/mag_cmp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
// The 3-bit result word is {equal, greater, lower}, so at most one bit is set.
package mag_cmp_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Controller states. IDLE waits for start, COMPARE walks the bits
    // MSB-first, and DONE holds the one-cycle done pulse.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Result encodings, ordered {equal, greater, lower}.
    localparam logic [2:0] NONE = 3'b000;
    localparam logic [2:0] EQ   = 3'b100;
    localparam logic [2:0] GT   = 3'b010;
    localparam logic [2:0] LT   = 3'b001;

    // Packs the three comparison flags into the result word.
    function automatic logic [2:0] encode_result(input logic eq,
                                                 input logic gt,
                                                 input logic lt);
        return {eq, gt, lt};
    endfunction

endpackage

// File: rtl/mag_bit_cell.sv
// Single-bit magnitude comparator cell, purely combinational.
// Exactly one of eq/gt/lt is high for any input pair.
module mag_bit_cell (
    input  logic ai,
    input  logic bi,
    output logic eq,
    output logic gt,
    output logic lt
);

    // One bit position: equal when both bits match, otherwise the set bit wins.
    always_comb begin
        eq = ~(ai ^ bi);
        gt = ai & ~bi;
        lt = ~ai & bi;
    end

endmodule

// File: rtl/mag_serial_cmp.sv
// Bit-serial, MSB-first magnitude comparator for two unsigned words.
//
// Handshake: start is a request sampled only while the controller is idle
// (busy=0 and done=0). The edge that sees start=1 in IDLE captures a and b;
// start seen in any other state is dropped, never queued. The result
// (equal/greater/lower) is valid from the done cycle onward and is held
// until the next accepted start clears it to 000.
//
// Latency: with p the first (highest) differing bit, done is high in the
// cycle after edge WIDTH-p counted from the accepting edge; equal operands
// behave as p=0. All outputs come straight from flops.
module mag_serial_cmp
    import mag_cmp_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic             greater,
    output logic             lower
);

    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    // State and datapath registers with their next-state values.
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2:0]       res_q, res_d;

    // Currently selected bit pair and the cell's verdict on it.
    logic bit_a, bit_b;
    logic bit_eq, bit_gt, bit_lt;

    // A one-bit operand has only bit 0; selecting it directly avoids
    // indexing a 1-bit vector with a 1-bit counter.
    generate
        if (WIDTH == 1) begin : g_sel_single
            assign bit_a = a_q[0];
            assign bit_b = b_q[0];
        end else begin : g_sel_indexed
            assign bit_a = a_q[idx_q];
            assign bit_b = b_q[idx_q];
        end
    endgenerate

    mag_bit_cell u_cell (
        .ai (bit_a),
        .bi (bit_b),
        .eq (bit_eq),
        .gt (bit_gt),
        .lt (bit_lt)
    );

    // Register every piece of state; reset aborts any compare in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= NONE;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    // Next-state and next-output decode; busy/done are recomputed every
    // cycle, operands, index and result hold unless a state updates them.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        res_d   = res_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IDX_TOP;
                    res_d   = NONE;
                    busy_d  = 1'b1;
                    state_d = COMPARE;
                end
            end

            COMPARE: begin
                if (!bit_eq) begin
                    // First differing bit decides the outcome.
                    res_d   = encode_result(1'b0, bit_gt, bit_lt);
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    // Every bit matched down to the LSB; leaving here is
                    // unconditional so the index can never wrap.
                    res_d   = EQ;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - IDX_ONE;
                    busy_d  = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign equal   = res_q[2];
    assign greater = res_q[1];
    assign lower   = res_q[0];

endmodule

// File: tb/tb_mag_serial_cmp.sv
// Self-checking bench for mag_serial_cmp: an 8-bit instance for the main
// scenarios and a 1-bit instance for the degenerate width.
module tb_mag_serial_cmp;

    localparam logic [2:0] R_NONE = 3'b000;
    localparam logic [2:0] R_EQ   = 3'b100;
    localparam logic [2:0] R_GT   = 3'b010;
    localparam logic [2:0] R_LT   = 3'b001;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       busy, done, equal, greater, lower;

    logic       start1;
    logic [0:0] a1, b1;
    logic       busy1, done1, equal1, greater1, lower1;

    int n_checks;
    int n_fail;

    logic [2:0] exp_q[$];
    int         lat_q[$];

    mag_serial_cmp #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .equal(equal), .greater(greater), .lower(lower)
    );

    mag_serial_cmp #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .equal(equal1), .greater(greater1), .lower(lower1)
    );

    // Clock and global time bound.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: result from plain unsigned compare, latency from the
    // highest differing bit (cycles from the start drive to done seen).
    function automatic logic [2:0] model_res(input logic [7:0] av, input logic [7:0] bv);
        if (av > bv) return R_GT;
        if (av < bv) return R_LT;
        return R_EQ;
    endfunction

    function automatic int model_lat(input logic [7:0] av, input logic [7:0] bv);
        logic [7:0] d;
        d = av ^ bv;
        for (int p = 7; p >= 0; p--)
            if (d[p]) return 8 - p + 1;
        return 8 + 1;
    endfunction

    // Driver: present operands with start and push the expectation.
    task automatic drive_start(input logic [7:0] av, input logic [7:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        exp_q.push_back(model_res(av, bv));
        lat_q.push_back(model_lat(av, bv));
    endtask

    // Waits (bounded) for done on the 8-bit instance, counting cycles.
    task automatic wait_done(input bit keep_start, output int cyc,
                             output int busy_cyc, output bit timeout);
        cyc = 0; busy_cyc = 0; timeout = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (!keep_start) start = 1'b0;
            if (done) begin timeout = 1'b0; break; end
            if (busy) busy_cyc++;
        end
    endtask

    task automatic test_reset;
        n_checks++;
        if ({busy, done, equal, greater, lower} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_w8: got %b expected 00000", {busy, done, equal, greater, lower});
        end
        n_checks++;
        if ({busy1, done1, equal1, greater1, lower1} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_w1: got %b expected 00000", {busy1, done1, equal1, greater1, lower1});
        end
    endtask

    // One compare with latency, busy length, result and hold checks.
    task automatic test_single(input string name, input logic [7:0] av, input logic [7:0] bv);
        int cyc, bcyc, lat;
        bit to;
        logic [2:0] exp;
        drive_start(av, bv);
        wait_done(1'b0, cyc, bcyc, to);
        exp = exp_q.pop_front();
        lat = lat_q.pop_front();
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL %s_timeout: no done within 40 cycles", name);
            return;
        end
        n_checks++;
        if (cyc !== lat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d expected %0d", name, cyc, lat);
        end
        n_checks++;
        if (bcyc !== lat - 1) begin
            n_fail++;
            $display("FAIL %s_busy_len: got %0d expected %0d", name, bcyc, lat - 1);
        end
        n_checks++;
        if ({equal, greater, lower} !== exp) begin
            n_fail++;
            $display("FAIL %s_result: got %b expected %b", name, {equal, greater, lower}, exp);
        end
        // Done must drop after one cycle while the result holds, even with
        // the operand inputs moving.
        a = ~av; b = ~bv;
        @(negedge clk);
        n_checks++;
        if ({busy, done, equal, greater, lower} !== {2'b00, exp}) begin
            n_fail++;
            $display("FAIL %s_hold: got %b expected %b", name, {busy, done, equal, greater, lower}, {2'b00, exp});
        end
    endtask

    // Start held high while busy with different operands: only the first
    // compare counts, the next accept comes in the IDLE cycle after done.
    task automatic test_busy_ignore;
        int k;
        bit seen;
        logic [2:0] exp;
        drive_start(8'h80, 8'h7F);
        k = 0; seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            k++;
            a = 8'h00; b = 8'hFF;
            if (done) begin seen = 1'b1; break; end
        end
        exp = exp_q.pop_front();
        void'(lat_q.pop_front());
        n_checks++;
        if (!seen || k !== 2) begin
            n_fail++;
            $display("FAIL busy_first_latency: got %0d expected 2", k);
        end
        n_checks++;
        if ({equal, greater, lower} !== exp) begin
            n_fail++;
            $display("FAIL busy_first_result: got %b expected %b", {equal, greater, lower}, exp);
        end
        exp_q.push_back(R_LT);
        k = 0; seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            k++;
            if (busy) begin seen = 1'b1; break; end
        end
        start = 1'b0;
        n_checks++;
        if (!seen || k !== 2) begin
            n_fail++;
            $display("FAIL busy_reaccept_delay: got %0d expected 2", k);
        end
        n_checks++;
        if ({done, equal, greater, lower} !== 4'b0000) begin
            n_fail++;
            $display("FAIL busy_clear_on_accept: got %b expected 0000", {done, equal, greater, lower});
        end
        k = 0; seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            k++;
            if (done) begin seen = 1'b1; break; end
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (!seen || k !== 1) begin
            n_fail++;
            $display("FAIL busy_second_latency: got %0d expected 1", k);
        end
        n_checks++;
        if ({equal, greater, lower} !== exp) begin
            n_fail++;
            $display("FAIL busy_second_result: got %b expected %b", {equal, greater, lower}, exp);
        end
        @(negedge clk);
    endtask

    // Asynchronous reset three cycles into COMPARE, then a fresh compare.
    task automatic test_reset_mid;
        int k, done_cnt;
        drive_start(8'h01, 8'h00);
        k = 0;
        for (int i = 0; i < 20 && k < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) k++;
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, equal, greater, lower} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %b expected 00000", {busy, done, equal, greater, lower});
        end
        void'(exp_q.pop_front());
        void'(lat_q.pop_front());
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        n_checks++;
        if (done_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", done_cnt);
        end
        test_single("after_reset", 8'h01, 8'h00);
    endtask

    // Randomised compares issued back to back (start in the IDLE cycle
    // right after done), half of them differing in a single chosen bit.
    task automatic test_back_to_back;
        logic [7:0] av, bv;
        for (int n = 0; n < 8; n++) begin
            av = 8'($urandom_range(0, 255));
            if (n % 2 == 0) bv = av ^ (8'h01 << $urandom_range(0, 7));
            else if (n == 3) bv = av;
            else bv = 8'($urandom_range(0, 255));
            test_single($sformatf("b2b%0d", n), av, bv);
        end
    endtask

    // One-bit build: both cases finish two cycles after start.
    task automatic test_width1(input string name, input logic av, input logic bv,
                               input logic [2:0] exp);
        int k;
        bit seen;
        a1[0] = av; b1[0] = bv; start1 = 1'b1;
        k = 0; seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            k++;
            start1 = 1'b0;
            if (done1) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (!seen || k !== 2) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d expected 2", name, k);
        end
        n_checks++;
        if ({equal1, greater1, lower1} !== exp) begin
            n_fail++;
            $display("FAIL %s_result: got %b expected %b", name, {equal1, greater1, lower1}, exp);
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        test_reset;
        rst = 1'b0;
        @(negedge clk);
        test_single("msb_gt", 8'hA5, 8'h5A);
        test_single("equal", 8'h3C, 8'h3C);
        test_single("lsb_lt", 8'h10, 8'h11);
        test_busy_ignore;
        test_reset_mid;
        test_back_to_back;
        test_width1("w1_gt", 1'b1, 1'b0, R_GT);
        test_width1("w1_eq", 1'b0, 1'b0, R_EQ);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
